// File: rtl/tile_scroll_ctrl.sv
// tile_scroll_ctrl
//   Frame sequencer for the falling-tile game. Owns the seven-row tile map
//   and the scroll offset, advances them once per frame tick, and hands each
//   new frame to the row renderer through the draw_go / draw_done handshake.
//   It also scores taps on the bottom visible row (line_5) and ends the game
//   on a wrong tap or on a tile that scrolls past line_5 untapped.
//
// Ports
//   clock, resetn        clock, async active-low reset
//   startn               active-low start key (used in IDLE and OVER only)
//   draw_done            renderer finished (used in WAIT_DONE only)
//   tap_valid, tap_col   one-cycle tap strobe with column 1..4
//   draw_go              one-cycle draw request
//   offset               scroll offset in pixels, 0..TILE_H-1
//   line_0..line_6       row contents, 0 = empty, 1..4 = tile column
//   main_st              one-hot state {OVER,WAIT_DONE,REQ_DRAW,ADVANCE,WAIT_TICK,IDLE}
//   score                tiles hit, saturating
//   frame_drop           pulses when a tick is lost while one is already pending
//   game_over            high while in OVER
module tile_scroll_ctrl #(
  parameter int         FRAME_DIV = 833333,
  parameter int         STEP      = 2,
  parameter int         TILE_H    = 40,
  parameter logic [7:0] LFSR_SEED = 8'hA5
) (
  input  logic       clock,
  input  logic       resetn,
  input  logic       startn,
  input  logic       draw_done,
  input  logic       tap_valid,
  input  logic [2:0] tap_col,
  output logic       draw_go,
  output logic [5:0] offset,
  output logic [2:0] line_0,
  output logic [2:0] line_1,
  output logic [2:0] line_2,
  output logic [2:0] line_3,
  output logic [2:0] line_4,
  output logic [2:0] line_5,
  output logic [2:0] line_6,
  output logic [5:0] main_st,
  output logic [7:0] score,
  output logic       frame_drop,
  output logic       game_over
);

  localparam int            CW       = (FRAME_DIV > 1) ? $clog2(FRAME_DIV) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(FRAME_DIV - 1);
  localparam logic [6:0]    STEP7    = 7'(STEP);
  localparam logic [6:0]    TILE_H7  = 7'(TILE_H);

  typedef enum logic [5:0] {
    S_IDLE      = 6'b000001,
    S_WAIT_TICK = 6'b000010,
    S_ADVANCE   = 6'b000100,
    S_REQ_DRAW  = 6'b001000,
    S_WAIT_DONE = 6'b010000,
    S_OVER      = 6'b100000
  } state_e;

  state_e          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            pending_q, pending_d;
  logic            frame_drop_q, frame_drop_d;
  logic [5:0]      offset_q, offset_d;
  logic [6:0][2:0] line_q, line_d;
  logic [7:0]      score_q, score_d;
  logic [7:0]      lfsr_q, lfsr_d;

  logic       start, running, tick;
  logic       tap_acc, tap_hit, tap_miss;
  logic       wrap, escape;
  logic [6:0] sum;

  // Shared decode used by both the FSM and the datapath.
  always_comb begin
    start    = ~startn;
    running  = (state_q != S_IDLE) && (state_q != S_OVER);
    tick     = running && (cnt_q == CNT_LAST);
    tap_acc  = tap_valid && ((state_q == S_WAIT_TICK) || (state_q == S_WAIT_DONE));
    tap_hit  = tap_acc && (line_q[5] != 3'd0) && (tap_col == line_q[5]);
    tap_miss = tap_acc && !tap_hit;
    // 7-bit sum so offset + STEP never aliases before the row-wrap compare.
    sum      = {1'b0, offset_q} + STEP7;
    wrap     = (sum >= TILE_H7);
    // A tile still sitting on line_5 when the map shifts has been missed.
    escape   = wrap && (line_q[5] != 3'd0);
  end

  // State register
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) state_q <= S_IDLE;
    else         state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:      if (start) state_d = S_REQ_DRAW;
      S_WAIT_TICK: begin
        if (tap_miss)               state_d = S_OVER;
        else if (tick || pending_q) state_d = S_ADVANCE;
      end
      S_ADVANCE:   state_d = escape ? S_OVER : S_REQ_DRAW;
      S_REQ_DRAW:  state_d = S_WAIT_DONE;
      S_WAIT_DONE: begin
        // A bad tap wins over a completing renderer in the same cycle.
        if (tap_miss)       state_d = S_OVER;
        else if (draw_done) state_d = S_WAIT_TICK;
      end
      S_OVER:      if (start) state_d = S_REQ_DRAW;
      default:     state_d = S_IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    draw_go    = (state_q == S_REQ_DRAW);
    game_over  = (state_q == S_OVER);
    main_st    = state_q;
    offset     = offset_q;
    line_0     = line_q[0];
    line_1     = line_q[1];
    line_2     = line_q[2];
    line_3     = line_q[3];
    line_4     = line_q[4];
    line_5     = line_q[5];
    line_6     = line_q[6];
    score      = score_q;
    frame_drop = frame_drop_q;
  end

  // Datapath next values
  always_comb begin
    cnt_d        = '0;
    pending_d    = pending_q;
    frame_drop_d = 1'b0;
    offset_d     = offset_q;
    line_d       = line_q;
    score_d      = score_q;
    lfsr_d       = lfsr_q;

    if (running) cnt_d = tick ? '0 : cnt_q + CW'(1);

    // At most one frame of backlog: a tick arriving while the renderer is
    // busy is remembered once; a further tick is dropped and reported.
    case (state_q)
      S_WAIT_TICK: if (tick || pending_q) pending_d = 1'b0;
      S_ADVANCE:   if (tick) pending_d = 1'b1;
      S_REQ_DRAW, S_WAIT_DONE: begin
        if (tick) begin
          if (pending_q) frame_drop_d = 1'b1;
          else           pending_d    = 1'b1;
        end
      end
      default: ;
    endcase

    if (state_q == S_ADVANCE) begin
      if (wrap) begin
        offset_d = 6'(sum - TILE_H7);
        for (int i = 6; i > 0; i--) line_d[i] = line_q[i-1];
        line_d[0] = {1'b0, lfsr_q[1:0]} + 3'd1;
        lfsr_d    = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
      end else begin
        offset_d = sum[5:0];
      end
    end

    if (tap_hit) begin
      line_d[5] = 3'd0;
      if (score_q != 8'hFF) score_d = score_q + 8'd1;
    end

    // Restart keeps the LFSR running so each game gets a new tile sequence.
    if ((state_q == S_OVER) && start) begin
      offset_d  = '0;
      line_d    = '0;
      score_d   = '0;
      pending_d = 1'b0;
    end
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      cnt_q        <= '0;
      pending_q    <= 1'b0;
      frame_drop_q <= 1'b0;
      offset_q     <= '0;
      line_q       <= '0;
      score_q      <= '0;
      lfsr_q       <= LFSR_SEED;
    end else begin
      cnt_q        <= cnt_d;
      pending_q    <= pending_d;
      frame_drop_q <= frame_drop_d;
      offset_q     <= offset_d;
      line_q       <= line_d;
      score_q      <= score_d;
      lfsr_q       <= lfsr_d;
    end
  end

endmodule

// File: tb/tb_tile_scroll_ctrl.sv
module tb_tile_scroll_ctrl;
  localparam int         FD   = 16;
  localparam int         STEP = 2;
  localparam int         TH   = 40;
  localparam logic [7:0] SEED = 8'hA5;

  logic       clock = 1'b0;
  logic       resetn = 1'b0;
  logic       startn = 1'b1;
  logic       draw_done = 1'b0;
  logic       tap_valid = 1'b0;
  logic [2:0] tap_col = 3'd0;
  logic       draw_go, frame_drop, game_over;
  logic [5:0] offset, main_st;
  logic [2:0] line_0, line_1, line_2, line_3, line_4, line_5, line_6;
  logic [7:0] score;
  logic [20:0] dut_lines;

  tile_scroll_ctrl #(.FRAME_DIV(FD), .STEP(STEP), .TILE_H(TH), .LFSR_SEED(SEED)) dut (
    .clock(clock), .resetn(resetn), .startn(startn), .draw_done(draw_done),
    .tap_valid(tap_valid), .tap_col(tap_col), .draw_go(draw_go), .offset(offset),
    .line_0(line_0), .line_1(line_1), .line_2(line_2), .line_3(line_3),
    .line_4(line_4), .line_5(line_5), .line_6(line_6), .main_st(main_st),
    .score(score), .frame_drop(frame_drop), .game_over(game_over)
  );

  always #5 clock = ~clock;
  assign dut_lines = {line_6, line_5, line_4, line_3, line_2, line_1, line_0};

  int errors = 0, checks = 0;
  int go_cnt = 0, fd_cnt = 0;
  // Reference game state: one entry per row, offset in pixels, score.
  int m_off, m_score;
  int m_line[7];
  logic [7:0] m_lfsr;

  initial begin
    #1_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1);
  end

  // Polynomial x^8+x^6+x^5+x^4+1, shifting toward the MSB.
  function automatic logic [7:0] lfsr_next(input logic [7:0] v);
    return {v[6:0], v[7] ^ v[5] ^ v[4] ^ v[3]};
  endfunction

  function automatic logic [20:0] exp_lines();
    logic [20:0] v = '0;
    for (int i = 0; i < 7; i++) v[i*3 +: 3] = 3'(m_line[i]);
    return v;
  endfunction

  task automatic model_clear(input bit with_lfsr);
    m_off = 0; m_score = 0;
    for (int i = 0; i < 7; i++) m_line[i] = 0;
    if (with_lfsr) m_lfsr = SEED;
  endtask

  task automatic model_advance(output bit esc);
    esc = 1'b0;
    m_off = m_off + STEP;
    if (m_off >= TH) begin
      m_off = m_off - TH;
      esc = (m_line[5] != 0);
      for (int i = 6; i > 0; i--) m_line[i] = m_line[i-1];
      m_line[0] = int'(m_lfsr % 4) + 1;
      m_lfsr = lfsr_next(m_lfsr);
    end
  endtask

  // Every cycle of the run passes through here; outputs are sampled at negedge.
  task automatic step();
    @(negedge clock);
    if (draw_go === 1'b1) go_cnt++;
    if (frame_drop === 1'b1) fd_cnt++;
  endtask

  // One frame: expected advance, wait for the draw request, check the frame,
  // answer after lat cycles. tmode 1 taps line_5 in WAIT_DONE, 2 in WAIT_TICK.
  task automatic do_frame(input bit adv, input int lat, input int tmode, input int bound,
                          output bit esc);
    int n = 0;
    esc = 1'b0;
    if (adv) model_advance(esc);
    while (draw_go !== 1'b1 && game_over !== 1'b1 && n < bound) begin step(); n++; end
    if (esc) begin
      checks++;
      if (game_over !== 1'b1 || draw_go !== 1'b0) begin
        errors++; $display("FAIL escape_over got over=%b go=%b exp over=1 go=0", game_over, draw_go);
      end
      checks++;
      if (dut_lines !== exp_lines()) begin
        errors++; $display("FAIL escape_lines got=%h exp=%h", dut_lines, exp_lines());
      end
      return;
    end
    checks++;
    if (draw_go !== 1'b1) begin
      errors++; $display("FAIL draw_go_wait got go=%b st=%b exp go=1 within %0d", draw_go, main_st, bound);
      return;
    end
    checks++;
    if (offset !== 6'(m_off)) begin
      errors++; $display("FAIL frame_offset got=%0d exp=%0d", offset, m_off);
    end
    checks++;
    if (dut_lines !== exp_lines()) begin
      errors++; $display("FAIL frame_lines got=%h exp=%h", dut_lines, exp_lines());
    end
    checks++;
    if (score !== 8'(m_score)) begin
      errors++; $display("FAIL frame_score got=%0d exp=%0d", score, m_score);
    end
    step();
    checks++;
    if (main_st !== 6'b010000 || draw_go !== 1'b0) begin
      errors++; $display("FAIL wait_done_entry got st=%b go=%b exp st=010000 go=0", main_st, draw_go);
    end
    for (int i = 0; i < lat - 1; i++) begin
      if (i == 0 && tmode == 1 && m_line[5] != 0) begin tap_valid = 1'b1; tap_col = 3'(m_line[5]); end
      step();
      if (tap_valid) begin
        tap_valid = 1'b0; m_line[5] = 0;
        if (m_score < 255) m_score++;
        checks++;
        if (line_5 !== 3'd0 || score !== 8'(m_score) || main_st !== 6'b010000) begin
          errors++; $display("FAIL tap_wait_done got l5=%0d sc=%0d st=%b exp l5=0 sc=%0d st=010000",
                             line_5, score, main_st, m_score);
        end
      end
    end
    draw_done = 1'b1; step(); draw_done = 1'b0;
    checks++;
    if (main_st !== 6'b000010) begin
      errors++; $display("FAIL done_to_wait_tick got=%b exp=000010", main_st);
    end
    if (tmode == 2 && m_line[5] != 0) begin
      tap_valid = 1'b1; tap_col = 3'(m_line[5]); step(); tap_valid = 1'b0;
      m_line[5] = 0;
      if (m_score < 255) m_score++;
      checks++;
      if (line_5 !== 3'd0 || score !== 8'(m_score) || game_over !== 1'b0) begin
        errors++; $display("FAIL tap_wait_tick got l5=%0d sc=%0d over=%b exp l5=0 sc=%0d over=0",
                           line_5, score, game_over, m_score);
      end
    end
  endtask

  task automatic test_reset();
    resetn = 1'b0; startn = 1'b1; draw_done = 1'b0; tap_valid = 1'b0;
    model_clear(1'b1);
    repeat (3) step();
    checks++;
    if (main_st !== 6'b000001 || draw_go !== 1'b0 || game_over !== 1'b0 || frame_drop !== 1'b0) begin
      errors++; $display("FAIL reset_ctrl got st=%b go=%b over=%b fd=%b exp 000001/0/0/0",
                         main_st, draw_go, game_over, frame_drop);
    end
    checks++;
    if (offset !== 6'd0 || dut_lines !== 21'd0 || score !== 8'd0) begin
      errors++; $display("FAIL reset_data got off=%0d lines=%h sc=%0d exp 0/0/0", offset, dut_lines, score);
    end
    resetn = 1'b1;
    repeat (4) step();
    checks++;
    if (main_st !== 6'b000001 || go_cnt != 0) begin
      errors++; $display("FAIL idle_hold got st=%b go_cnt=%0d exp 000001/0", main_st, go_cnt);
    end
  endtask

  // Start from IDLE or restart from OVER: the first draw is of an empty map.
  task automatic test_start();
    bit esc;
    int g0 = go_cnt;
    model_clear(1'b0);
    startn = 1'b0; step(); startn = 1'b1;
    do_frame(1'b0, 3, 0, 4, esc);
    checks++;
    if (go_cnt != g0 + 1) begin
      errors++; $display("FAIL start_go_count got=%0d exp=%0d", go_cnt - g0, 1);
    end
  endtask

  task automatic test_scroll();
    bit esc;
    for (int f = 0; f < 20; f++) do_frame(1'b1, 3, 0, FD + 8, esc);
    checks++;
    if (line_0 !== 3'd2 || offset !== 6'd0) begin
      errors++; $display("FAIL first_shift got l0=%0d off=%0d exp l0=2 off=0", line_0, offset);
    end
  endtask

  task automatic test_pending();
    bit esc;
    int f0 = fd_cnt;
    do_frame(1'b1, 2 * FD, 0, FD + 8, esc);
    checks++;
    if (fd_cnt - f0 != 1) begin
      errors++; $display("FAIL frame_drop_count got=%0d exp=1", fd_cnt - f0);
    end
    // The pending tick must start the next advance without a fresh tick.
    do_frame(1'b1, 3, 0, 5, esc);
  endtask

  task automatic test_tap();
    bit esc;
    for (int f = 0; f < 400 && m_score < 4; f++)
      do_frame(1'b1, $urandom_range(2, 5), (m_score == 0) ? 2 : $urandom_range(1, 2), FD + 8, esc);
    checks++;
    if (score !== 8'd4 || game_over !== 1'b0) begin
      errors++; $display("FAIL tap_score got sc=%0d over=%b exp sc=4 over=0", score, game_over);
    end
  endtask

  task automatic test_reset_mid();
    bit esc;
    int n = 0;
    model_advance(esc);
    while (draw_go !== 1'b1 && n < FD + 8) begin step(); n++; end
    step();
    checks++;
    if (main_st !== 6'b010000) begin
      errors++; $display("FAIL reset_mid_setup got=%b exp=010000", main_st);
    end
    #2 resetn = 1'b0;
    #1;
    checks++;
    if (main_st !== 6'b000001 || draw_go !== 1'b0 || game_over !== 1'b0 || frame_drop !== 1'b0 ||
        offset !== 6'd0 || dut_lines !== 21'd0 || score !== 8'd0) begin
      errors++; $display("FAIL reset_mid got st=%b go=%b off=%0d lines=%h sc=%0d exp 000001/0/0/0/0",
                         main_st, draw_go, offset, dut_lines, score);
    end
    step(); resetn = 1'b1; step();
    model_clear(1'b1);
  endtask

  task automatic test_escape();
    bit esc = 1'b0;
    int g0;
    for (int f = 0; f < 200 && !esc; f++) do_frame(1'b1, $urandom_range(2, 5), 0, FD + 8, esc);
    checks++;
    if (!esc || main_st !== 6'b100000) begin
      errors++; $display("FAIL escape_reached got esc=%b st=%b exp esc=1 st=100000", esc, main_st);
    end
    g0 = go_cnt;
    repeat (2 * FD) step();
    checks++;
    if (go_cnt != g0 || game_over !== 1'b0 + 1'b1 || offset !== 6'(m_off)) begin
      errors++; $display("FAIL over_frozen got go=%0d over=%b off=%0d exp go=0 over=1 off=%0d",
                         go_cnt - g0, game_over, offset, m_off);
    end
  endtask

  // Wrong column in WAIT_DONE together with draw_done: the miss must win.
  task automatic test_miss();
    bit esc;
    int n = 0;
    int g0;
    for (int f = 0; f < 200 && m_line[5] == 0; f++) do_frame(1'b1, $urandom_range(2, 5), 0, FD + 8, esc);
    model_advance(esc);
    while (draw_go !== 1'b1 && n < FD + 8) begin step(); n++; end
    step();
    tap_valid = 1'b1; tap_col = 3'((m_line[5] % 4) + 1); draw_done = 1'b1;
    step();
    tap_valid = 1'b0; draw_done = 1'b0;
    checks++;
    if (game_over !== 1'b1 || main_st !== 6'b100000) begin
      errors++; $display("FAIL miss_over got over=%b st=%b exp over=1 st=100000", game_over, main_st);
    end
    g0 = go_cnt;
    repeat (2 * FD) step();
    checks++;
    if (go_cnt != g0 || dut_lines !== exp_lines() || score !== 8'(m_score)) begin
      errors++; $display("FAIL miss_frozen got go=%0d lines=%h sc=%0d exp go=0 lines=%h sc=%0d",
                         go_cnt - g0, dut_lines, score, exp_lines(), m_score);
    end
  endtask

  task automatic test_after_restart();
    bit esc;
    for (int f = 0; f < 20; f++) do_frame(1'b1, $urandom_range(2, 5), 0, FD + 8, esc);
    checks++;
    if (fd_cnt != 1) begin
      errors++; $display("FAIL total_frame_drop got=%0d exp=1", fd_cnt);
    end
  endtask

  initial begin
    test_reset();
    test_start();
    test_scroll();
    test_pending();
    test_tap();
    test_reset_mid();
    test_start();
    test_escape();
    test_start();
    test_miss();
    test_start();
    test_after_restart();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
